cache_snoop_ctrl: RTL and testbench
===================================

// Module: cache_snoop_ctrl
// PURPOSE
//  Per-processor write-back cache controller (MSI) feeding the two-processor bus arbiter.
//  Services CPU reads/writes from a direct-mapped line store, raises PLCK to request the bus,
//  and waits for SLCK low (granted) before issuing bus ops.
//  Snoops the peer's bus ops and drives PHIT/PHITM, which the arbiter uses to prioritise.
// PARAMETERS
//  ADDR_W   8   byte address width; one word per line
//  DATA_W   8   data word width
//  IDX_W    2   index bits; LINES = 2**IDX_W; tag = ADDR_W-IDX_W bits
// PORTS
//  SCLK       in   1       system clock, all state on posedge
//  SRST       in   1       reset, asynchronous, active-low
//  CPU_REQ    in   1       CPU access request; held until CPU_ACK
//  CPU_WE     in   1       1=write, 0=read; valid with CPU_REQ
//  CPU_ADDR   in   ADDR_W  access address
//  CPU_WDATA  in   DATA_W  write data
//  CPU_RDATA  out  DATA_W  read data, valid while CPU_ACK=1
//  CPU_ACK    out  1       one-cycle completion pulse
//  PLCK       out  1       bus request to arbiter; 1=requesting
//  SLCK       in   1       grant from arbiter; 0=granted
//  BUS_VALID  out  1       bus op issued this cycle (one-cycle pulse)
//  BUS_OP     out  2       00 BusRd, 01 BusRdX, 10 WriteBack
//  BUS_ADDR   out  ADDR_W  bus op address
//  BUS_WDATA  out  DATA_W  write-back / flush data
//  BUS_RDATA  in   DATA_W  fill data, valid with BUS_ACK
//  BUS_ACK    in   1       memory completion of the outstanding op
//  SNP_VALID  in   1       peer bus op present
//  SNP_OP     in   2       peer op code (same encoding as BUS_OP)
//  SNP_ADDR   in   ADDR_W  peer op address
//  PHIT       out  1       snoop hit (registered)
//  PHITM      out  1       snoop hit on Modified line (registered)
// BEHAVIOUR
//  Reset: all lines Invalid; every output 0, CPU_RDATA=0; FSM=IDLE.
//  Line state 2b: I=00, S=01, M=11. FSM: IDLE->LOOKUP->{DONE | REQ->[WB]->FILL->DONE}->IDLE.
//  IDLE: CPU_REQ=1 latches addr/we/wdata, -> LOOKUP next cycle.
//  LOOKUP hit cases: read on S/M, or write on M -> DONE (write sets M, updates data).
//  LOOKUP miss (tag mismatch/I, or write to S) -> REQ: PLCK=1 from next cycle.
//  REQ: stay while SLCK=1. When SLCK=0: victim M and tag differs -> WB; else -> FILL.
//  WB: BUS_VALID pulse, OP=10, ADDR={victim tag,idx}, WDATA=victim data; wait BUS_ACK -> FILL.
//  FILL: BUS_VALID pulse, OP=00 (read) or 01 (write); wait BUS_ACK; install tag;
//   read -> S with BUS_RDATA; write -> M with CPU_WDATA merged; -> DONE.
//  PLCK held high from REQ entry until the BUS_ACK ending FILL; dropped in DONE.
//  DONE: CPU_ACK=1 one cycle, CPU_RDATA = line data; -> IDLE. Hit latency 2 cycles after REQ.
//  If SLCK returns to 1 mid-WB/FILL, the op still completes (grant is sampled once, in REQ).
//  Snoop: SNP_VALID with tag match on non-I line, result registered next cycle (PHIT/PHITM
//   valid for exactly one cycle):
//   M: PHIT=1,PHITM=1; BusRd -> S, BusRdX -> I. S: PHIT=1,PHITM=0; BusRdX -> I.
//   miss/I or SNP_OP=10: PHIT=0,PHITM=0; no state change.
//  Snoop and local update same line same cycle: snoop transition applied first, then local
//   FSM re-evaluates; a line invalidated while in REQ is re-filled (no stale hit).
//  Async reset mid-transaction: immediate return to reset state, PLCK=0 at once.
// CONFIGURATION
//  PERF_CNT_EN defined: adds outputs HIT_CNT[15:0], MISS_CNT[15:0], +1 per LOOKUP outcome,
//   saturating at 16'hFFFF, cleared by SRST. Undefined: ports and counters absent.
// TESTING
//  Read 0x14 cold -> PLCK=1, SLCK=0 -> BusRd 0x14, BUS_RDATA=0xA5 -> CPU_RDATA=0xA5, line S.
//  Repeat read 0x14 -> CPU_ACK 2 cycles after CPU_REQ, no PLCK, no BUS_VALID.
//  Write 0x14=0x3C (line S) -> BusRdX 0x14, line M; snoop BusRd 0x14 -> PHIT=1,PHITM=1, line S.
//  Line 0x14 M, read 0x24 (same idx 0) -> WriteBack 0x14 data 0x3C, then BusRd 0x24.
//  Hold SLCK=1 for 10 cycles in REQ -> PLCK stays 1, no BUS_VALID; SLCK=0 -> op issues next.
//  SRST low during FILL -> PLCK=0, PHIT=PHITM=0, all lines I; post-reset read of 0x14 misses.

Source files
------------

// File: rtl/cache_snoop_ctrl.sv
// Direct-mapped MSI write-back cache controller with bus request/grant handshake and peer snoop.
// Build option PERF_CNT_EN adds saturating HIT_CNT / MISS_CNT lookup counters.
module cache_snoop_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic              SCLK,
    input  logic              SRST,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              CPU_ACK,
    output logic              PLCK,
    input  logic              SLCK,
    output logic              BUS_VALID,
    output logic [1:0]        BUS_OP,
    output logic [ADDR_W-1:0] BUS_ADDR,
    output logic [DATA_W-1:0] BUS_WDATA,
    input  logic [DATA_W-1:0] BUS_RDATA,
    input  logic              BUS_ACK,
    input  logic              SNP_VALID,
    input  logic [1:0]        SNP_OP,
    input  logic [ADDR_W-1:0] SNP_ADDR,
    output logic              PHIT,
    output logic              PHITM
`ifdef PERF_CNT_EN
    ,
    output logic [15:0]       HIT_CNT,
    output logic [15:0]       MISS_CNT
`endif
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {LS_I = 2'b00, LS_S = 2'b01, LS_M = 2'b11} line_t;
    typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_REQ, ST_WB, ST_FILL, ST_DONE} state_t;

    line_t             line_st   [LINES];
    logic [TAG_W-1:0]  line_tag  [LINES];
    logic [DATA_W-1:0] line_data [LINES];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic [IDX_W-1:0]  req_idx, snp_idx;
    logic [TAG_W-1:0]  req_tag, snp_tag;

    logic              snp_hit;
    line_t             snp_cur, snp_next, eff_st;
    logic              tag_match, lookup_hit, victim_wb;
    logic [DATA_W-1:0] done_data;

    assign req_idx = req_addr[IDX_W-1:0];
    assign req_tag = req_addr[ADDR_W-1:IDX_W];
    assign snp_idx = SNP_ADDR[IDX_W-1:0];
    assign snp_tag = SNP_ADDR[ADDR_W-1:IDX_W];

    // Peer snoop: only BusRd / BusRdX on a valid matching line count as hits
    always_comb begin
        snp_cur  = line_st[snp_idx];
        snp_next = snp_cur;
        snp_hit  = 1'b0;
        if (SNP_VALID && snp_cur != LS_I && line_tag[snp_idx] == snp_tag &&
            (SNP_OP == 2'b00 || SNP_OP == 2'b01)) begin
            snp_hit = 1'b1;
            if (SNP_OP == 2'b01)
                snp_next = LS_I;
            else if (snp_cur == LS_M)
                snp_next = LS_S;
        end
    end

    // Local decisions see the line as it will be after this cycle's snoop
    always_comb begin
        eff_st     = (snp_hit && snp_idx == req_idx) ? snp_next : line_st[req_idx];
        tag_match  = (line_tag[req_idx] == req_tag);
        lookup_hit = tag_match && (req_we ? (eff_st == LS_M) : (eff_st != LS_I));
        victim_wb  = (eff_st == LS_M) && !tag_match;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (CPU_REQ) state_d = ST_LOOKUP;
            ST_LOOKUP: state_d = lookup_hit ? ST_DONE : ST_REQ;
            ST_REQ:    if (!SLCK) state_d = victim_wb ? ST_WB : ST_FILL;
            ST_WB:     if (BUS_ACK) state_d = ST_FILL;
            ST_FILL:   if (BUS_ACK) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        BUS_OP    = 2'b00;
        BUS_ADDR  = '0;
        BUS_WDATA = '0;
        if (state_q == ST_WB) begin
            BUS_OP    = 2'b10;
            BUS_ADDR  = {line_tag[req_idx], req_idx};
            BUS_WDATA = line_data[req_idx];
        end else if (state_q == ST_FILL) begin
            BUS_OP   = {1'b0, req_we};
            BUS_ADDR = req_addr;
        end
    end

    always_comb begin
        if (state_q == ST_FILL)
            done_data = req_we ? req_wdata : BUS_RDATA;
        else
            done_data = req_we ? req_wdata : line_data[req_idx];
    end

    assign CPU_ACK = (state_q == ST_DONE);
    assign PLCK    = (state_q == ST_REQ) || (state_q == ST_WB) || (state_q == ST_FILL);

    always_ff @(posedge SCLK or negedge SRST) begin
        if (!SRST) begin
            state_q   <= ST_IDLE;
            BUS_VALID <= 1'b0;
            PHIT      <= 1'b0;
            PHITM     <= 1'b0;
            CPU_RDATA <= '0;
            for (int i = 0; i < LINES; i++)
                line_st[i] <= LS_I;
        end else begin
            state_q   <= state_d;
            BUS_VALID <= (state_d == ST_WB && state_q != ST_WB) ||
                         (state_d == ST_FILL && state_q != ST_FILL);
            PHIT      <= snp_hit;
            PHITM     <= snp_hit && (snp_cur == LS_M);
            if (snp_hit)
                line_st[snp_idx] <= snp_next;
            // Local update lands after the snoop so a same-cycle install wins
            if (state_q == ST_LOOKUP && lookup_hit && req_we)
                line_st[req_idx] <= LS_M;
            if (state_q == ST_FILL && BUS_ACK)
                line_st[req_idx] <= req_we ? LS_M : LS_S;
            if (state_d == ST_DONE && state_q != ST_DONE)
                CPU_RDATA <= done_data;
        end
    end

    always_ff @(posedge SCLK) begin
        if (state_q == ST_IDLE && CPU_REQ) begin
            req_addr  <= CPU_ADDR;
            req_we    <= CPU_WE;
            req_wdata <= CPU_WDATA;
        end
        if (state_q == ST_LOOKUP && lookup_hit && req_we)
            line_data[req_idx] <= req_wdata;
        if (state_q == ST_FILL && BUS_ACK) begin
            line_tag[req_idx]  <= req_tag;
            line_data[req_idx] <= done_data;
        end
    end

`ifdef PERF_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge SCLK or negedge SRST) begin
        if (!SRST) begin
            HIT_CNT  <= '0;
            MISS_CNT <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (lookup_hit)
                HIT_CNT <= sat_inc(HIT_CNT);
            else
                MISS_CNT <= sat_inc(MISS_CNT);
        end
    end
`endif

endmodule

// File: tb/tb_cache_snoop_ctrl.sv
// Bench for cache_snoop_ctrl: directed vector table, reset corner sequences, and random
// CPU/snoop traffic checked against an address-level MSI cache model.
module tb_cache_snoop_ctrl;

    logic       clk = 1'b0;
    logic       srst_n = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0;
    logic [7:0] cpu_rdata;
    logic       cpu_ack, plck;
    logic       slck = 1'b1;
    logic       bus_valid;
    logic [1:0] bus_op;
    logic [7:0] bus_addr, bus_wdata;
    logic [7:0] bus_rdata = '0;
    logic       bus_ack = 1'b0;
    logic       snp_valid = 1'b0;
    logic [1:0] snp_op = '0;
    logic [7:0] snp_addr = '0;
    logic       phit, phitm;
`ifdef PERF_CNT_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    cache_snoop_ctrl dut (
        .SCLK(clk), .SRST(srst_n),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
        .CPU_RDATA(cpu_rdata), .CPU_ACK(cpu_ack),
        .PLCK(plck), .SLCK(slck),
        .BUS_VALID(bus_valid), .BUS_OP(bus_op), .BUS_ADDR(bus_addr), .BUS_WDATA(bus_wdata),
        .BUS_RDATA(bus_rdata), .BUS_ACK(bus_ack),
        .SNP_VALID(snp_valid), .SNP_OP(snp_op), .SNP_ADDR(snp_addr),
        .PHIT(phit), .PHITM(phitm)
`ifdef PERF_CNT_EN
        , .HIT_CNT(hit_cnt), .MISS_CNT(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;      // 0 CPU access, 1 snoop
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         nops;
        logic [1:0] op0;
        logic [7:0] addr0;
        logic [7:0] wd0;
        logic [1:0] op1;
        logic [7:0] addr1;
        logic [7:0] rdata;
        logic       phit;
        logic       phitm;
        int         gdly;
        bit         bounce;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    int         m_addr  [4];
    int         m_st    [4];   // 0 invalid, 1 shared, 2 modified
    logic [7:0] m_data  [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkc(input logic we, input logic [7:0] a, input logic [7:0] wd,
                                 input int n, input logic [1:0] o0, input logic [7:0] a0,
                                 input logic [7:0] w0, input logic [1:0] o1,
                                 input logic [7:0] a1, input logic [7:0] rd);
        vec_t v;
        v.kind = 0; v.we = we; v.addr = a; v.wdata = wd; v.nops = n;
        v.op0 = o0; v.addr0 = a0; v.wd0 = w0; v.op1 = o1; v.addr1 = a1; v.rdata = rd;
        v.phit = 1'b0; v.phitm = 1'b0; v.gdly = 0; v.bounce = 1'b0;
        return v;
    endfunction

    function automatic vec_t mks(input logic [1:0] op, input logic [7:0] a,
                                 input logic h, input logic hm);
        vec_t v;
        v = mkc(1'b0, a, 8'h00, 0, op, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00);
        v.kind = 1; v.phit = h; v.phitm = hm;
        return v;
    endfunction

    // CPU access with a bus responder: grant after gdly PLCK cycles, memory ack after lat cycles
    task automatic do_cpu(input vec_t v, input int gdly, input int lat, input bit bounce);
        int nseen, plck_n, grant_at, first_vld, pend, first_plck;
        bit granted, done;
        logic [7:0] pend_addr;
        logic [1:0] eop;
        logic [7:0] ead;
        nseen = 0; plck_n = 0; grant_at = -1; first_vld = -1; pend = 0; first_plck = -1;
        granted = 1'b0; done = 1'b0; pend_addr = '0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; slck = 1'b1;
        for (int idx = 1; idx <= 400 && !done; idx++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (cpu_ack) begin
                done = 1'b1;
                cpu_req = 1'b0;
                slck = 1'b1;
                chk("cpu_rdata", cpu_rdata, v.rdata);
                chk("bus_op_count", nseen, v.nops);
                chk("plck_low_in_done", plck, 1'b0);
                if (v.nops == 0) chk("hit_latency", idx, 2);
                else             chk("plck_rise_cycle", first_plck, 2);
            end else begin
                if (plck && first_plck < 0) first_plck = idx;
                if (bus_valid) begin
                    if (first_vld < 0) begin
                        first_vld = idx;
                        chk("op_after_grant", idx, grant_at + 1);
                    end
                    chk("plck_during_op", plck, 1'b1);
                    if (nseen < v.nops) begin
                        eop = (nseen == 0) ? v.op0 : v.op1;
                        ead = (nseen == 0) ? v.addr0 : v.addr1;
                        chk("bus_op", bus_op, eop);
                        chk("bus_addr", bus_addr, ead);
                        if (eop == 2'b10) chk("wb_data", bus_wdata, v.wd0);
                    end else begin
                        chk("unexpected_bus_op", nseen + 1, v.nops);
                    end
                    if (bus_op == 2'b10) mem[bus_addr] = bus_wdata;
                    pend = lat;
                    pend_addr = bus_addr;
                    nseen++;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus_ack = 1'b1;
                        bus_rdata = mem[pend_addr];
                    end
                end
                if (plck && !granted) begin
                    if (plck_n >= gdly) begin
                        slck = 1'b0; granted = 1'b1; grant_at = idx;
                    end
                    plck_n++;
                end else if (granted && bounce) begin
                    slck = 1'b1;
                end
            end
        end
        if (!done) begin
            cpu_req = 1'b0; slck = 1'b1; bus_ack = 1'b0;
            chk("cpu_ack_timeout", 0, 1);
        end
    endtask

    task automatic do_snoop(input logic [1:0] op, input logic [7:0] a,
                            input logic eh, input logic ehm);
        @(negedge clk);
        snp_valid = 1'b1; snp_op = op; snp_addr = a;
        @(negedge clk);
        snp_valid = 1'b0;
        chk("phit", phit, eh);
        chk("phitm", phitm, ehm);
        @(negedge clk);
        chk("snoop_pulse_width", {phit, phitm}, 2'b00);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = -1; m_st[i] = 0; m_data[i] = '0;
        end
    endtask

    task automatic model_cpu(input logic we, input logic [7:0] a, input logic [7:0] wd,
                             output vec_t v);
        int  i;
        bit  hit;
        i = int'(a) % 4;
        hit = (m_addr[i] == int'(a)) && (we ? (m_st[i] == 2) : (m_st[i] != 0));
        v = mkc(we, a, wd, 0, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00);
        if (hit) begin
            if (we) m_data[i] = wd;
        end else begin
            if (m_st[i] == 2 && m_addr[i] != int'(a)) begin
                v.nops = 2;
                v.op0 = 2'b10; v.addr0 = 8'(m_addr[i]); v.wd0 = m_data[i];
                v.op1 = {1'b0, we}; v.addr1 = a;
                ref_mem[m_addr[i]] = m_data[i];
            end else begin
                v.nops = 1;
                v.op0 = {1'b0, we}; v.addr0 = a;
            end
            m_addr[i] = int'(a);
            m_st[i]   = we ? 2 : 1;
            m_data[i] = we ? wd : ref_mem[a];
        end
        v.rdata = m_data[i];
    endtask

    task automatic model_snoop(input logic [1:0] op, input logic [7:0] a,
                               output logic eh, output logic ehm);
        int i;
        i = int'(a) % 4;
        eh = 1'b0; ehm = 1'b0;
        if (m_addr[i] == int'(a) && m_st[i] != 0 && op != 2'b10) begin
            eh = 1'b1;
            ehm = (m_st[i] == 2);
            if (op == 2'b01)     m_st[i] = 0;
            else if (m_st[i] == 2) m_st[i] = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t tbl [14];
        vec_t v;
        bit   found;
        logic eh, ehm;
        logic [7:0] a, wd;
        logic [1:0] sop;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h14] = 8'hA5; mem[8'h24] = 8'h5A; mem[8'h25] = 8'h11;

        tbl[0]  = mkc(0, 8'h14, 8'h00, 1, 2'b00, 8'h14, 8'h00, 2'b00, 8'h00, 8'hA5);
        tbl[1]  = mkc(0, 8'h14, 8'h00, 0, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'hA5);
        tbl[2]  = mkc(1, 8'h14, 8'h3C, 1, 2'b01, 8'h14, 8'h00, 2'b00, 8'h00, 8'h3C);
        tbl[3]  = mks(2'b00, 8'h14, 1'b1, 1'b1);
        tbl[4]  = mkc(1, 8'h14, 8'h3C, 1, 2'b01, 8'h14, 8'h00, 2'b00, 8'h00, 8'h3C);
        tbl[5]  = mkc(0, 8'h24, 8'h00, 2, 2'b10, 8'h14, 8'h3C, 2'b00, 8'h24, 8'h5A);
        tbl[6]  = mks(2'b01, 8'h24, 1'b1, 1'b0);
        tbl[7]  = mkc(0, 8'h24, 8'h00, 1, 2'b00, 8'h24, 8'h00, 2'b00, 8'h00, 8'h5A);
        tbl[8]  = mks(2'b10, 8'h24, 1'b0, 1'b0);
        tbl[9]  = mks(2'b00, 8'h34, 1'b0, 1'b0);
        tbl[10] = mkc(1, 8'h24, 8'h66, 1, 2'b01, 8'h24, 8'h00, 2'b00, 8'h00, 8'h66);
        tbl[11] = mkc(1, 8'h24, 8'h67, 0, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h67);
        tbl[12] = mkc(0, 8'h25, 8'h00, 1, 2'b00, 8'h25, 8'h00, 2'b00, 8'h00, 8'h11);
        tbl[13] = mkc(0, 8'h14, 8'h00, 2, 2'b10, 8'h24, 8'h67, 2'b00, 8'h14, 8'h3C);
        tbl[7].gdly    = 10;
        tbl[13].bounce = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_plck", plck, 1'b0);
        chk("rst_bus_valid", bus_valid, 1'b0);
        chk("rst_bus_op", bus_op, 2'b00);
        chk("rst_bus_addr", bus_addr, 8'h00);
        chk("rst_phit", {phit, phitm}, 2'b00);
        srst_n = 1'b1;

        for (int t = 0; t < 14; t++) begin
            if (tbl[t].kind == 1)
                do_snoop(tbl[t].op0, tbl[t].addr, tbl[t].phit, tbl[t].phitm);
            else
                do_cpu(tbl[t], tbl[t].gdly, 2, tbl[t].bounce);
        end

        // Asynchronous reset while a fill is outstanding
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h35; slck = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (bus_valid) found = 1'b1;
            if (plck) slck = 1'b0;
        end
        chk("abort_fill_issued", found, 1'b1);
        chk("abort_fill_op", bus_op, 2'b00);
        snp_valid = 1'b1; snp_op = 2'b00; snp_addr = 8'h25;
        @(posedge clk);
        #1;
        snp_valid = 1'b0;
        chk("abort_prereset_phit", phit, 1'b1);
        chk("abort_prereset_plck", plck, 1'b1);
        #2 srst_n = 1'b0;
        #1;
        chk("abort_plck", plck, 1'b0);
        chk("abort_phit", {phit, phitm}, 2'b00);
        chk("abort_bus_valid", bus_valid, 1'b0);
        chk("abort_cpu_ack", cpu_ack, 1'b0);
        cpu_req = 1'b0; slck = 1'b1;
        @(negedge clk);
        srst_n = 1'b1;

        model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        model_cpu(1'b0, 8'h14, 8'h00, v);
        do_cpu(mkc(0, 8'h14, 8'h00, 1, 2'b00, 8'h14, 8'h00, 2'b00, 8'h00, 8'h3C), 0, 1, 1'b0);

        // Random traffic over a small address pool to force hits, conflicts and snoops
        for (int n = 0; n < 200; n++) begin
            a = 8'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                sop = 2'($urandom_range(0, 2));
                model_snoop(sop, a, eh, ehm);
                do_snoop(sop, a, eh, ehm);
            end else begin
                wd = 8'($urandom);
                model_cpu(1'($urandom_range(0, 1)), a, wd, v);
                do_cpu(v, $urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
